// File: rtl/frac_lut6_cfg_loader.sv
// Serial configuration loader for a chain of frac_lut6 instances.
// Shifts 66-bit words MSB first into the ccff chain and captures tail readback.
module frac_lut6_cfg_loader #(
    parameter int NUM_LUTS = 10,
    localparam int CFG_BITS = 66,
    localparam int IDX_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                cfg_valid,
    input  logic [CFG_BITS-1:0] cfg_data,
    output logic                cfg_ready,
    output logic                ccff_head,
    output logic                ccff_en,
    input  logic                ccff_tail,
    output logic                rb_valid,
    output logic [CFG_BITS-1:0] rb_data,
    output logic                busy,
    output logic [IDX_W-1:0]    lut_idx,
    output logic                done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [6:0]       LAST_BIT = 7'(CFG_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LUTS - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CFG_BITS-1:0] shreg;
    logic [CFG_BITS-1:0] shifted;
    logic [6:0]          bit_cnt;
    logic                accept;
    logic                last_bit;

    // Tail is sampled on the same edge the chain shifts, so this is the
    // tail value from before the shift.
    assign shifted = {shreg[CFG_BITS-2:0], ccff_tail};

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        last_bit  = 1'b0;
        unique case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                accept    = cfg_valid;
                if (cfg_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                ccff_en   = 1'b1;
                busy      = 1'b1;
                ccff_head = shreg[CFG_BITS-1];
                last_bit  = (bit_cnt == LAST_BIT);
                if (last_bit) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            rb_valid <= 1'b0;
            rb_data  <= '0;
            done     <= 1'b0;
            lut_idx  <= '0;
        end else begin
            state    <= state_nxt;
            rb_valid <= 1'b0;
            done     <= 1'b0;
            if (accept) begin
                shreg   <= cfg_data;
                bit_cnt <= '0;
            end else if (ccff_en) begin
                shreg   <= shifted;
                bit_cnt <= bit_cnt + 7'd1;
            end
            if (last_bit) begin
                rb_valid <= 1'b1;
                rb_data  <= shifted;
                if (lut_idx == LAST_IDX) begin
                    lut_idx <= '0;
                    done    <= 1'b1;
                end else begin
                    lut_idx <= lut_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_frac_lut6_cfg_loader.sv
// Directed bench for frac_lut6_cfg_loader with external ccff chain models.
// Covers single load, full cluster passes, backpressure, resets, NUM_LUTS=1.
module tb_frac_lut6_cfg_loader;

    localparam int N = 10;
    localparam int CW = N * 66;

    logic        prog_clk = 1'b0;
    logic        pReset;
    logic        cfg_valid;
    logic [65:0] cfg_data;
    logic        cfg_ready;
    logic        ccff_head;
    logic        ccff_en;
    logic        ccff_tail;
    logic        rb_valid;
    logic [65:0] rb_data;
    logic        busy;
    logic [3:0]  lut_idx;
    logic        done;

    logic        cfg_valid1;
    logic [65:0] cfg_data1;
    logic        cfg_ready1;
    logic        ccff_head1;
    logic        ccff_en1;
    logic        ccff_tail1;
    logic        rb_valid1;
    logic [65:0] rb_data1;
    logic        busy1;
    logic [0:0]  lut_idx1;
    logic        done1;

    logic          chain_fill;
    logic [CW-1:0] chain;
    logic [65:0]   chain1;
    logic [65:0]   head_seq;
    int            en_cnt = 0;
    int            done_cnt = 0;
    int            cyc = 0;

    int tests = 0;
    int fails = 0;

    always #5 prog_clk = ~prog_clk;

    frac_lut6_cfg_loader #(.NUM_LUTS(N)) dut (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .ccff_head (ccff_head),
        .ccff_en   (ccff_en),
        .ccff_tail (ccff_tail),
        .rb_valid  (rb_valid),
        .rb_data   (rb_data),
        .busy      (busy),
        .lut_idx   (lut_idx),
        .done      (done)
    );

    frac_lut6_cfg_loader #(.NUM_LUTS(1)) dut1 (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .cfg_valid (cfg_valid1),
        .cfg_data  (cfg_data1),
        .cfg_ready (cfg_ready1),
        .ccff_head (ccff_head1),
        .ccff_en   (ccff_en1),
        .ccff_tail (ccff_tail1),
        .rb_valid  (rb_valid1),
        .rb_data   (rb_data1),
        .busy      (busy1),
        .lut_idx   (lut_idx1),
        .done      (done1)
    );

    // External configuration chains: shift on enabled edges, tail = last flop.
    assign ccff_tail  = chain[CW-1];
    assign ccff_tail1 = chain1[65];

    always @(posedge prog_clk) begin
        if (chain_fill) begin
            chain  <= '1;
            chain1 <= '1;
        end else begin
            if (ccff_en)  chain  <= {chain[CW-2:0], ccff_head};
            if (ccff_en1) chain1 <= {chain1[64:0], ccff_head1};
        end
    end

    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (ccff_en) begin
            head_seq <= {head_seq[64:0], ccff_head};
            en_cnt   <= en_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [65:0] obs,
                         input logic [65:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_rb(input string tag, input int lim);
        int n;
        n = 0;
        while (rb_valid !== 1'b1 && n < lim) begin
            @(negedge prog_clk);
            n++;
        end
        check(tag, 66'(rb_valid), 66'd1);
    endtask

    task automatic wait_ready(input string tag, input int lim);
        int n;
        n = 0;
        while (cfg_ready !== 1'b1 && n < lim) begin
            @(negedge prog_clk);
            n++;
        end
        check(tag, 66'(cfg_ready), 66'd1);
    endtask

    logic [65:0] W0 = 66'h2_AAAA_5555_F0F0_0F0F;
    logic [65:0] B3 = 66'h1_DEAD_BEEF_0BAD_F00D;
    logic [65:0] B4 = 66'h3_1234_5678_9ABC_DEF0;
    logic [65:0] B5 = 66'h0_FFFF_0000_AAAA_5555;
    logic [65:0] E0 = 66'h2_0000_FFFF_1111_EEEE;
    logic [65:0] E1 = 66'h1_5A5A_A5A5_3C3C_C3C3;
    logic [65:0] D [N];

    function automatic logic [65:0] rb_exp(input int j);
        if (j < N - 1)  return '1;
        if (j == N - 1) return W0;
        return D[j-N];
    endfunction

    initial begin
        int c0;
        int pc;
        int e0;
        int dc0;
        int n;
        logic any_ready;

        for (int i = 0; i < N; i++)
            D[i] = {2'(i), 32'hC0DE_0000 | 32'(i),
                    ~(32'hC0DE_0000 | 32'(i))};

        pReset     = 1'b1;
        chain_fill = 1'b1;
        cfg_valid  = 1'b0;
        cfg_data   = '0;
        cfg_valid1 = 1'b0;
        cfg_data1  = '0;
        repeat (3) @(negedge prog_clk);
        pReset     = 1'b0;
        chain_fill = 1'b0;

        check("rst_ready", 66'(cfg_ready), 66'd1);
        check("rst_en",    66'(ccff_en),   66'd0);
        check("rst_head",  66'(ccff_head), 66'd0);
        check("rst_busy",  66'(busy),      66'd0);
        check("rst_rbv",   66'(rb_valid),  66'd0);
        check("rst_rbd",   rb_data,        66'd0);
        check("rst_done",  66'(done),      66'd0);
        check("rst_idx",   66'(lut_idx),   66'd0);

        // Single load into an all-ones chain
        cfg_valid = 1'b1;
        cfg_data  = W0;
        c0 = cyc;
        e0 = en_cnt;
        @(negedge prog_clk);
        cfg_valid = 1'b0;
        check("t1_busy",  66'(busy),      66'd1);
        check("t1_ready", 66'(cfg_ready), 66'd0);
        wait_rb("t1_rb_wait", 100);
        check("t1_rb_cyc", 66'(cyc - c0),    66'd67);
        check("t1_en_cnt", 66'(en_cnt - e0), 66'd66);
        check("t1_head",   head_seq,         W0);
        check("t1_rbd",    rb_data,          '1);
        check("t1_idx",    66'(lut_idx),     66'd1);
        check("t1_done",   66'(done),        66'd0);

        // Full cluster: two back-to-back passes with cfg_valid held high
        pReset = 1'b1;
        @(negedge prog_clk);
        pReset = 1'b0;
        check("t2_idx0", 66'(lut_idx), 66'd0);
        dc0 = done_cnt;
        cfg_valid = 1'b1;
        pc = 0;
        for (int i = 0; i < 2 * N; i++) begin
            cfg_data = D[i % N];
            wait_ready("t2_ready", 200);
            if (i == 0) c0 = cyc;
            if (i > 0) begin
                check("t2_gap", 66'(cyc - pc),  66'd67);
                check("t2_rbv", 66'(rb_valid),  66'd1);
                check("t2_rbd", rb_data,        rb_exp(i - 1));
            end
            if (i == N) begin
                check("t2_done_cyc", 66'(cyc - c0), 66'd670);
                check("t2_done",     66'(done),     66'd1);
                check("t2_idx_wrap", 66'(lut_idx),  66'd0);
            end
            pc = cyc;
            @(negedge prog_clk);
        end
        cfg_valid = 1'b0;
        wait_rb("t2_rb_wait", 100);
        check("t2_last_rbd", rb_data,      D[N-1]);
        check("t2_last_done", 66'(done),   66'd1);
        check("t2_last_idx", 66'(lut_idx), 66'd0);
        @(negedge prog_clk);
        check("t2_done_pulse", 66'(done),           66'd0);
        check("t2_done_cnt",   66'(done_cnt - dc0), 66'd2);

        // Backpressure: noise on valid/data while shifting
        cfg_valid = 1'b1;
        cfg_data  = B3;
        e0 = en_cnt;
        @(negedge prog_clk);
        any_ready = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cfg_valid = (k % 2) == 1;
            cfg_data  = {$urandom, $urandom, $urandom};
            if (cfg_ready) any_ready = 1'b1;
            @(negedge prog_clk);
        end
        cfg_valid = 1'b0;
        check("t3_no_ready", 66'(any_ready), 66'd0);
        wait_rb("t3_rb_wait", 100);
        check("t3_head",   head_seq,         B3);
        check("t3_en_cnt", 66'(en_cnt - e0), 66'd66);
        check("t3_rbd",    rb_data,          D[0]);
        check("t3_idx",    66'(lut_idx),     66'd1);
        repeat (3) @(negedge prog_clk);
        check("t3_no_extra", 66'(en_cnt - e0), 66'd66);

        // Reset while bit_cnt == 30
        cfg_valid = 1'b1;
        cfg_data  = B4;
        @(negedge prog_clk);
        cfg_valid = 1'b0;
        repeat (30) @(negedge prog_clk);
        check("t4_busy_pre", 66'(busy), 66'd1);
        pReset = 1'b1;
        @(negedge prog_clk);
        pReset = 1'b0;
        check("t4_ready", 66'(cfg_ready), 66'd1);
        check("t4_en",    66'(ccff_en),   66'd0);
        check("t4_head",  66'(ccff_head), 66'd0);
        check("t4_busy",  66'(busy),      66'd0);
        check("t4_rbv",   66'(rb_valid),  66'd0);
        check("t4_rbd",   rb_data,        66'd0);
        check("t4_done",  66'(done),      66'd0);
        check("t4_idx",   66'(lut_idx),   66'd0);
        cfg_valid = 1'b1;
        cfg_data  = B5;
        c0 = cyc;
        e0 = en_cnt;
        @(negedge prog_clk);
        cfg_valid = 1'b0;
        wait_rb("t4_rb_wait", 100);
        check("t4_rb_cyc", 66'(cyc - c0),    66'd67);
        check("t4_seq",    head_seq,         B5);
        check("t4_en_cnt", 66'(en_cnt - e0), 66'd66);
        check("t4_idx1",   66'(lut_idx),     66'd1);

        // Reset and handshake on the same edge
        pReset    = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = W0;
        e0 = en_cnt;
        @(negedge prog_clk);
        pReset    = 1'b0;
        cfg_valid = 1'b0;
        check("t5_en",    66'(ccff_en),   66'd0);
        check("t5_busy",  66'(busy),      66'd0);
        check("t5_ready", 66'(cfg_ready), 66'd1);
        check("t5_idx",   66'(lut_idx),   66'd0);
        repeat (5) @(negedge prog_clk);
        check("t5_no_shift", 66'(en_cnt - e0), 66'd0);

        // NUM_LUTS=1 instance: done after every word, index stays 0
        for (int j = 0; j < 2; j++) begin
            cfg_valid1 = 1'b1;
            cfg_data1  = (j == 0) ? E0 : E1;
            n = 0;
            while (cfg_ready1 !== 1'b1 && n < 200) begin
                @(negedge prog_clk);
                n++;
            end
            check("t6_ready", 66'(cfg_ready1), 66'd1);
            @(negedge prog_clk);
            cfg_valid1 = 1'b0;
            n = 0;
            while (rb_valid1 !== 1'b1 && n < 100) begin
                @(negedge prog_clk);
                n++;
            end
            check("t6_rbv",  66'(rb_valid1), 66'd1);
            check("t6_done", 66'(done1),     66'd1);
            check("t6_idx",  66'(lut_idx1),  66'd0);
            check("t6_rbd",  rb_data1,       (j == 0) ? '1 : E0);
            @(negedge prog_clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
